// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: canonical NOP, default reset vector and
// fetch FSM state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Instruction fetch only ever targets word boundaries.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Squash beats load, load beats hold; a squashed
// entry carries a NOP with a zero PC so it is indistinguishable from reset.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        squash,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    logic [31:0] pc_d,    pc_q;
    logic [31:0] pc4_d,   pc4_q;
    logic [31:0] inst_d,  inst_q;
    logic        valid_d, valid_q;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (squash) begin
            pc_d    = 32'd0;
            pc4_d   = 32'd0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (load) begin
            pc_d    = pc_in;
            pc4_d   = pc_in + PC_STEP;
            inst_d  = inst_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign pc4_out   = pc4_q;
    assign inst_out  = inst_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection, RUN/HALT
// control and the IF/ID register feeding decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_DEPTH = 81
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        fetch_halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] DEPTH_WORDS = 32'(IMEM_DEPTH);

    fetch_state_t state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  fetch_count_d, fetch_count_q;
    logic         fetch_halted_d, fetch_halted_q;
    logic         ifid_load, ifid_squash;
    logic         pc_oob;

    assign pc_oob = (pc_q >> 2) >= DEPTH_WORDS;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_squash = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d        = align_word(redirect_target);
                    ifid_squash = 1'b1;
                end else if (flush) begin
                    ifid_squash = 1'b1;
                    if (!stall) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pc_oob) begin
                    ifid_squash = 1'b1;
                    state_d     = HALT;
                end else begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + PC_STEP;
                end
            end
            HALT: begin
                // Keep IF/ID squashed; only a redirect can restart fetch.
                ifid_squash = 1'b1;
                if (redirect) begin
                    pc_d    = align_word(redirect_target);
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        fetch_count_d  = ifid_load ? sat_inc32(fetch_count_q) : fetch_count_q;
        fetch_halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            fetch_count_q  <= 32'd0;
            fetch_halted_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_count_q  <= fetch_count_d;
            fetch_halted_q <= fetch_halted_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (ifid_load),
        .squash    (ifid_squash),
        .pc_in     (pc_q),
        .inst_in   (imem_inst),
        .pc_out    (ifid_pc),
        .pc4_out   (ifid_pc4),
        .inst_out  (ifid_inst),
        .valid_out (ifid_valid)
    );

    assign imem_pc      = pc_q;
    assign fetch_halted = fetch_halted_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory and
// a queue of expected IF/ID contents, one entry per clock edge.
module tb_fetch_stage;

    localparam int          DEPTH = 81;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_pc, imem_inst;
    logic [31:0] ifid_pc, ifid_pc4, ifid_inst;
    logic        ifid_valid, fetch_halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [DEPTH];
    ifid_t       exp_q[$];
    ifid_t       last_exp;
    logic [31:0] exp_count;
    logic        exp_halted;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        if ((imem_pc >> 2) < DEPTH) imem_inst = mem[imem_pc[31:2]];
        else                        imem_inst = 32'hDEAD_BEEF;
    end

    fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_pc         (imem_pc),
        .imem_inst       (imem_inst),
        .ifid_pc         (ifid_pc),
        .ifid_pc4        (ifid_pc4),
        .ifid_inst       (ifid_inst),
        .ifid_valid      (ifid_valid),
        .fetch_halted    (fetch_halted),
        .fetch_count     (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic exp_fetch(input logic [31:0] pc);
        ifid_t e;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.inst  = mem[pc[31:2]];
        e.valid = 1'b1;
        exp_q.push_back(e);
        exp_count++;
    endtask

    task automatic exp_nop();
        ifid_t e;
        e.pc = 32'd0; e.pc4 = 32'd0; e.inst = NOP; e.valid = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_hold();
        exp_q.push_back(last_exp);
    endtask

    // Advance one edge, then compare the DUT against the oldest expectation.
    task automatic tick(input logic [31:0] exp_imem_pc);
        ifid_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
            check("ifid_inst", ifid_inst, e.inst);
            if (e.valid) begin
                check("ifid_pc", ifid_pc, e.pc);
                check("ifid_pc4", ifid_pc4, e.pc4);
            end
        end
        check("imem_pc", imem_pc, exp_imem_pc);
        check("fetch_count", fetch_count, exp_count);
        check("fetch_halted", {31'd0, fetch_halted}, {31'd0, exp_halted});
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] t);
        stall = s; flush = f; redirect = r; redirect_target = t;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0010_0093 + (i << 20) + (i << 7);
        mem[0] = 32'h1930_0293;
        reset = 1'b1;
        drive(0, 0, 0, 32'h0);
        exp_count  = 32'd0;
        exp_halted = 1'b0;
        last_exp.pc = 0; last_exp.pc4 = 0; last_exp.inst = NOP; last_exp.valid = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_pc", imem_pc, 32'h0);
        check("rst_ifid_pc", ifid_pc, 32'h0);
        check("rst_ifid_pc4", ifid_pc4, 32'h0);
        check("rst_ifid_inst", ifid_inst, NOP);
        check("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_fetch_halted", {31'd0, fetch_halted}, 32'd0);
        reset = 1'b0;

        // First fetch and free run
        exp_fetch(32'h0); tick(32'h4);
        check("first_inst", ifid_inst, 32'h1930_0293);
        exp_fetch(32'h4); tick(32'h8);
        exp_fetch(32'h8); tick(32'hC);

        // Stall freezes PC, IF/ID and count
        drive(1, 0, 0, 32'h0);
        exp_hold(); tick(32'hC);
        exp_hold(); tick(32'hC);
        check("stall_ifid_pc", ifid_pc, 32'h8);
        drive(0, 0, 0, 32'h0);
        exp_fetch(32'hC); tick(32'h10);

        // Redirect with stall, misaligned target
        drive(1, 0, 1, 32'h62);
        exp_nop(); tick(32'h60);
        drive(0, 0, 0, 32'h0);
        exp_fetch(32'h60); tick(32'h64);

        // Flush alone at PC=0x20, then flush with stall
        drive(0, 0, 1, 32'h20);
        exp_nop(); tick(32'h20);
        drive(0, 1, 0, 32'h0);
        exp_nop(); tick(32'h24);
        drive(1, 1, 0, 32'h0);
        exp_nop(); tick(32'h24);
        drive(0, 0, 0, 32'h0);

        // Sequential fetch to the end of memory, then halt
        for (int pc = 32'h24; pc < 32'h144; pc += 4) begin
            exp_fetch(pc); tick(pc + 4);
        end
        exp_nop(); exp_halted = 1'b1; tick(32'h144);
        drive(1, 1, 0, 32'h0);
        exp_nop(); tick(32'h144);
        drive(0, 0, 0, 32'h0);
        exp_nop(); tick(32'h144);

        // Redirect to an OOB target: RUN for one edge, then HALT again
        drive(0, 0, 1, 32'h200);
        exp_nop(); exp_halted = 1'b0; tick(32'h200);
        drive(0, 0, 0, 32'h0);
        exp_nop(); exp_halted = 1'b1; tick(32'h200);

        // Redirect back to word 0 restarts fetch
        drive(0, 0, 1, 32'h0);
        exp_nop(); exp_halted = 1'b0; tick(32'h0);
        drive(0, 0, 0, 32'h0);
        for (int pc = 0; pc < 32'h40; pc += 4) begin
            exp_fetch(pc); tick(pc + 4);
        end

        // Reset mid-stream with redirect asserted
        reset = 1'b1;
        drive(0, 0, 1, 32'h80);
        exp_nop(); exp_count = 32'd0; exp_halted = 1'b0; tick(32'h0);
        check("midrst_ifid_pc", ifid_pc, 32'h0);
        reset = 1'b0;
        drive(0, 0, 0, 32'h0);
        exp_fetch(32'h0); tick(32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
